// File: rtl/cs_pkg.sv
// Shared state codes and constants for the CS sequencer family (cs_seq and cs_cmd successors).
package cs_pkg;

  typedef enum logic [3:0] {
    ST_WAIT = 4'h3,
    ST_POST = 4'h4,
    ST_IDLE = 4'h8,
    ST_MCFC = 4'h9,
    ST_UPRX = 4'hA,
    ST_FIFR = 4'hB,
    ST_ERR  = 4'hE,
    ST_SEND = 4'hF
  } cs_state_e;

  localparam int POST_LEN = 4;

  // Handshake stages that are guarded by the timeout counter.
  function automatic logic tmo_stage(input cs_state_e s);
    return (s == ST_MCFC) || (s == ST_FIFR) || (s == ST_SEND);
  endfunction

endpackage

// File: rtl/cs_tmo.sv
// Per-stage timeout counter: counts while enabled, expires as the count reaches limit (0 disables).
module cs_tmo #(
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expire
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  // Fires during the cycle whose edge brings the count up to limit, so a stage lasts exactly limit cycles.
  assign expire = enable && (limit != '0) && (cnt == limit - 1'b1);

endmodule

// File: rtl/cs_seq.sv
// CS transaction sequencer: MAC->FIFO-C->CS handshake chain with per-stage timeout and error state.
// Optional SEND stage and fs_send/fs_recv ports are built when CS_SEQ_SEND_EN is defined.
module cs_seq import cs_pkg::*; #(
  parameter int               NUM_FIFO = 3,
  parameter int               TMO_W    = 16,
  parameter logic [TMO_W-1:0] TMO_MAX  = 16'hFFFF,
  parameter int               CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_FIFO-1:0] fifo_full,
  input  logic                fs_udp_rx,
  output logic                fs_mac2fifoc,
  input  logic                fd_mac2fifoc,
  output logic                fd_udp_rx,
  output logic                fs_fifoc2cs,
  input  logic                fd_fifoc2cs,
  input  logic                err_clr,
  output logic                err,
  output logic [CNT_W-1:0]    tx_cnt,
  output logic [3:0]          led_cont
`ifdef CS_SEQ_SEND_EN
  ,
  output logic                fs_send,
  input  logic                fs_recv
`endif
);

  localparam int PW = (POST_LEN > 1) ? $clog2(POST_LEN) : 1;

`ifdef CS_SEQ_SEND_EN
  localparam cs_state_e AFTER_FIFR = ST_SEND;
`else
  localparam cs_state_e AFTER_FIFR = ST_POST;
`endif

  // Reset asserts asynchronously but releases two edges later, in step with clk.
  logic [1:0] rst_pipe;
  logic       rst_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= '0;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_s = rst_pipe[1];

  cs_state_e       state, state_nxt;
  logic [PW-1:0]   post_cnt;
  logic            tmo_exp;

  cs_tmo #(.TMO_W(TMO_W)) u_tmo (
    .clk    (clk),
    .rst    (rst_s),
    .clear  (state_nxt != state),
    .enable (tmo_stage(state)),
    .limit  (TMO_MAX),
    .expire (tmo_exp)
  );

  // Done is tested before expiry so a same-cycle done still completes the stage.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!(|fifo_full)) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (|fifo_full)     state_nxt = ST_IDLE;
        else if (fs_udp_rx) state_nxt = ST_MCFC;
      end
      ST_MCFC: begin
        if (fd_mac2fifoc) state_nxt = ST_UPRX;
        else if (tmo_exp) state_nxt = ST_ERR;
      end
      ST_UPRX: if (!fs_udp_rx) state_nxt = ST_FIFR;
      ST_FIFR: begin
        if (fd_fifoc2cs)  state_nxt = AFTER_FIFR;
        else if (tmo_exp) state_nxt = ST_ERR;
      end
`ifdef CS_SEQ_SEND_EN
      ST_SEND: begin
        if (fs_recv)      state_nxt = ST_POST;
        else if (tmo_exp) state_nxt = ST_ERR;
      end
`endif
      ST_POST: if (post_cnt == PW'(POST_LEN - 1)) state_nxt = ST_IDLE;
      ST_ERR:  if (err_clr) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state    <= ST_IDLE;
      post_cnt <= '0;
      tx_cnt   <= '0;
    end else begin
      state    <= state_nxt;
      post_cnt <= (state == ST_POST) ? post_cnt + 1'b1 : '0;
      if (state_nxt == ST_POST && state != ST_POST) tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign led_cont     = state;
  assign fs_mac2fifoc = (state == ST_MCFC);
  assign fd_udp_rx    = (state == ST_UPRX);
  assign fs_fifoc2cs  = (state == ST_FIFR);
  assign err          = (state == ST_ERR);
`ifdef CS_SEQ_SEND_EN
  assign fs_send      = (state == ST_SEND);
`endif

endmodule

// File: tb/tb_cs_seq.sv
// Self-checking bench for cs_seq: randomized handshake delays against a stage-sequence model.
module tb_cs_seq;

  localparam int CNT_W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fifo_full = '0;
  logic       fs_udp_rx = 1'b0;
  logic       fs_mac2fifoc, fd_mac2fifoc = 1'b0;
  logic       fd_udp_rx;
  logic       fs_fifoc2cs, fd_fifoc2cs = 1'b0;
  logic       err_clr = 1'b0;
  logic       err;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0] led_cont;
`ifdef CS_SEQ_SEND_EN
  logic       fs_send, fs_recv = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int exp_tx = 0;

  cs_seq #(.NUM_FIFO(3), .TMO_W(16), .TMO_MAX(16'd10), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_full    (fifo_full),
    .fs_udp_rx    (fs_udp_rx),
    .fs_mac2fifoc (fs_mac2fifoc),
    .fd_mac2fifoc (fd_mac2fifoc),
    .fd_udp_rx    (fd_udp_rx),
    .fs_fifoc2cs  (fs_fifoc2cs),
    .fd_fifoc2cs  (fd_fifoc2cs),
    .err_clr      (err_clr),
    .err          (err),
    .tx_cnt       (tx_cnt),
    .led_cont     (led_cont)
`ifdef CS_SEQ_SEND_EN
    ,
    .fs_send      (fs_send),
    .fs_recv      (fs_recv)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every stage output is a pure decode of the visible state code.
  task automatic see(input string tag, input logic [3:0] code);
    chk({tag, ".led"},    32'(led_cont),     32'(code));
    chk({tag, ".fs_mac"}, 32'(fs_mac2fifoc), 32'(code == 4'h9));
    chk({tag, ".fd_udp"}, 32'(fd_udp_rx),    32'(code == 4'hA));
    chk({tag, ".fs_fc"},  32'(fs_fifoc2cs),  32'(code == 4'hB));
    chk({tag, ".err"},    32'(err),          32'(code == 4'hE));
`ifdef CS_SEQ_SEND_EN
    chk({tag, ".fs_send"}, 32'(fs_send),     32'(code == 4'hF));
`endif
  endtask

  task automatic wait_code(input string tag, input logic [3:0] code);
    int n = 0;
    while (led_cont !== code && n < 6) begin
      tick();
      n++;
    end
    chk(tag, 32'(led_cont), 32'(code));
  endtask

  // Starts and ends at a WAIT sample; each stage lasts (delay+1) cycles with done on the last.
  task automatic run_txn(input int dm, input int du, input int df);
    int w = $urandom_range(0, 2);
`ifdef CS_SEQ_SEND_EN
    int ds = $urandom_range(0, 3);
`endif
    for (int i = 0; i < w; i++) begin
      fs_udp_rx = 1'b0;
      tick();
      see("wait", 4'h3);
    end
    fs_udp_rx   = 1'b1;
    fd_fifoc2cs = 1'b1;  // stray done outside its stage must be ignored
    tick();
    for (int i = 0; i <= dm; i++) begin
      see("mcfc", 4'h9);
      fd_mac2fifoc = (i == dm);
      tick();
    end
    fd_mac2fifoc = 1'b0;
    fd_fifoc2cs  = 1'b0;
    for (int i = 0; i <= du; i++) begin
      see("uprx", 4'hA);
      fs_udp_rx = (i != du);
      tick();
    end
    for (int i = 0; i <= df; i++) begin
      see("fifr", 4'hB);
      fd_fifoc2cs = (i == df);
      tick();
    end
    fd_fifoc2cs = 1'b0;
`ifdef CS_SEQ_SEND_EN
    for (int i = 0; i <= ds; i++) begin
      see("send", 4'hF);
      fs_recv = (i == ds);
      tick();
    end
    fs_recv = 1'b0;
`endif
    exp_tx = (exp_tx + 1) % (1 << CNT_W);
    for (int i = 0; i < 4; i++) begin
      see("post", 4'h4);
      if (i == 0) chk("tx_cnt", 32'(tx_cnt), 32'(exp_tx));
      tick();
    end
    see("idle", 4'h8);
    tick();
    see("wait", 4'h3);
  endtask

  initial begin
    #1 rst = 1'b0;
    #11;
    see("rst", 4'h8);
    chk("rst.tx", 32'(tx_cnt), 32'd0);
    tick();
    tick();
    see("rst_hold", 4'h8);
    rst = 1'b1;
    tick();
    see("sync1", 4'h8);
    wait_code("to_wait", 4'h3);

    // Four full transactions: tx_cnt walks 1,2,3,0
    for (int t = 0; t < 4; t++)
      run_txn($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4));

    // Done arriving on the very cycle the timeout would fire wins
    run_txn(9, $urandom_range(0, 2), 9);

    // Full beats fs_udp_rx in WAIT
    fifo_full = 3'b010;
    fs_udp_rx = 1'b1;
    tick();
    see("full_pri", 4'h8);
    for (int i = 0; i < 2; i++) begin
      fifo_full = 3'($urandom_range(1, 7));
      tick();
      see("full_hold", 4'h8);
    end
    fifo_full = '0;
    fs_udp_rx = 1'b0;
    tick();
    see("full_rel", 4'h3);

    // MCFC withheld: ten MCFC cycles, then ERR
    fs_udp_rx = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      see("tmo_mcfc", 4'h9);
      tick();
    end
    see("tmo_err", 4'hE);
    chk("tmo_err.tx", 32'(tx_cnt), 32'(exp_tx));
    fs_udp_rx    = 1'b0;
    fd_mac2fifoc = 1'b1;
    tick();
    see("err_hold", 4'hE);
    fd_mac2fifoc = 1'b0;
    err_clr      = 1'b1;
    tick();
    see("err_clr", 4'h8);
    err_clr = 1'b0;
    chk("err_clr.tx", 32'(tx_cnt), 32'(exp_tx));
    tick();
    see("post_err", 4'h3);

    // Reset dropped mid-FIFR takes effect without a clock edge
    fs_udp_rx = 1'b1;
    tick();
    see("r_mcfc", 4'h9);
    fd_mac2fifoc = 1'b1;
    tick();
    see("r_uprx", 4'hA);
    fd_mac2fifoc = 1'b0;
    fs_udp_rx    = 1'b0;
    tick();
    see("r_fifr", 4'hB);
    #3 rst = 1'b0;
    #1;
    see("rst_async", 4'h8);
    chk("rst_async.tx", 32'(tx_cnt), 32'd0);
    exp_tx = 0;
    tick();
    rst = 1'b1;
    wait_code("rst_wait", 4'h3);
    run_txn($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
